usr_sequencer: RTL and testbench

Command-driven controller for the 8-bit universal shift register datapath. It accepts one command at a time over a valid/ready handshake and drives the register's 2-bit mode select and parallel-data inputs for the required number of cycles. It supplies the hold function the datapath lacks by reloading the register's own output, then pulses `done`. It sits between the host-side control logic and one universal shift register instance.

---
 rtl/usr_sequencer_if.sv | 27 ++
 rtl/usr_sequencer.sv | 100 ++++++++++
 tb/tb_usr_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/usr_sequencer_if.sv
// rtl/usr_sequencer_if.sv - command handshake bundle between host control logic and usr_sequencer
interface usr_sequencer_if #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [BITS-1:0]  cmd_data;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_op,
    output cmd_data,
    output cmd_count
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_op,
    input  cmd_data,
    input  cmd_count
  );
endinterface

// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - sequences load/shift/rotate commands onto a universal shift register
module usr_sequencer #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  usr_sequencer_if.slave    cmd,
  input  logic [BITS-1:0]   i_usr_q,
  output logic [1:0]        o_usr_ctrl,
  output logic [BITS-1:0]   o_usr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [BITS-1:0]   o_result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_SHL  = 2'd1;
  localparam logic [1:0] OP_ROL  = 2'd2;

  localparam logic [1:0] MODE_SHL  = 2'd0;
  localparam logic [1:0] MODE_ROL  = 2'd1;
  localparam logic [1:0] MODE_ROR  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [BITS-1:0]  r_data;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_k;

  logic             w_accept;
  logic             w_last;
  logic [BITS-1:0]  w_fill_src;
  logic             w_fill;

  assign cmd.cmd_ready = i_reset && (r_state == S_IDLE);
  assign w_accept      = cmd.cmd_ready && cmd.cmd_valid;
  assign w_last        = (r_op == OP_LOAD) || (r_k == r_count - CNT_W'(1));

  // Shifting past the top of the captured word yields zero fill bits for k >= BITS.
  assign w_fill_src = r_data >> r_k;
  assign w_fill     = w_fill_src[0];

  assign o_busy   = i_reset && (r_state != S_IDLE);
  assign o_done   = i_reset && (r_state == S_DONE);
  assign o_result = i_usr_q;

  // Default drive is a self-reload, standing in for the hold mode the register lacks.
  always_comb begin
    o_usr_ctrl = MODE_LOAD;
    o_usr_data = i_usr_q;
    if (i_reset && (r_state == S_EXEC)) begin
      case (r_op)
        OP_LOAD: o_usr_data = r_data;
        OP_SHL: begin
          o_usr_ctrl = MODE_SHL;
          o_usr_data = {{(BITS-1){1'b0}}, w_fill};
        end
        OP_ROL:  o_usr_ctrl = MODE_ROL;
        default: o_usr_ctrl = MODE_ROR;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd.cmd_op;
            r_data  <= cmd.cmd_data;
            r_count <= cmd.cmd_count;
            r_k     <= '0;
            if (cmd.cmd_op == OP_LOAD || cmd.cmd_count != '0)
              r_state <= S_EXEC;
            else
              r_state <= S_DONE;
          end
        end
        S_EXEC: begin
          if (w_last)
            r_state <= S_DONE;
          else
            r_k <= r_k + CNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usr_sequencer.sv
// tb/tb_usr_sequencer.sv - scoreboard bench for usr_sequencer driving a behavioural shift register
module tb_usr_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] usr_q = 8'h3C;
  logic [1:0] usr_ctrl;
  logic [7:0] usr_data;
  logic       busy, done;
  logic [7:0] result;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic       prev_done = 1'b0;

  usr_sequencer_if #(.BITS(8), .CNT_W(4)) bus ();

  usr_sequencer #(.BITS(8), .CNT_W(4)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .cmd        (bus.slave),
    .i_usr_q    (usr_q),
    .o_usr_ctrl (usr_ctrl),
    .o_usr_data (usr_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  always #5 clk = ~clk;

  // Universal shift register model: 0 shl with dataIn[0], 1 rol, 2 ror, 3 load.
  always @(posedge clk) begin
    case (usr_ctrl)
      2'd0:    usr_q <= {usr_q[6:0], usr_data[0]};
      2'd1:    usr_q <= {usr_q[6:0], usr_q[7]};
      2'd2:    usr_q <= {usr_q[0], usr_q[7:1]};
      default: usr_q <= usr_data;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", {24'd0, result}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_done = done;
  end

  // Returns at the negedge right after the accepting edge E0; fields are scrambled afterwards.
  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                       input logic [7:0] req, input bit push);
    int budget = 60;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    while (!bus.cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    if (push) exp_q.push_back(req);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~op;
    bus.cmd_data  = ~data;
    bus.cmd_count = ~cnt;
  endtask

  task automatic expect_done_at(input int n, input string name);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check({name, "_done_timing"}, {31'd0, done}, {31'd0, (i == n)});
    end
    if (n == 0) check({name, "_done_timing"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    int budget = 60;
    while (!bus.cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.cmd_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                     input logic [7:0] req, input string name);
    issue(op, data, cnt, req, 1'b1);
    expect_done_at((op == 2'd0) ? 1 : int'(cnt), name);
    @(negedge clk);
    check({name, "_ready_after_done"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [7:0] shl_seq [4] = '{8'h01, 8'h03, 8'h06, 8'h0D};

  initial begin
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 8'h00;
    bus.cmd_count = 4'd0;

    repeat (2) begin
      @(negedge clk);
      check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_ctrl",  {30'd0, usr_ctrl}, 32'd3);
      check("rst_data",  {24'd0, usr_data}, 32'h3C);
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("idle_ctrl",  {30'd0, usr_ctrl}, 32'd3);
      check("idle_data",  {24'd0, usr_data}, 32'h3C);
      check("idle_reg",   {24'd0, usr_q}, 32'h3C);
    end

    issue(2'd0, 8'hA5, 4'd7, 8'hA5, 1'b1);
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_drive_ctrl", {30'd0, usr_ctrl}, 32'd3);
    check("load_drive_data", {24'd0, usr_data}, 32'hA5);
    @(negedge clk);
    check("load_reg_e1", {24'd0, usr_q}, 32'hA5);
    check("load_done", {31'd0, done}, 32'd1);
    check("load_ready_in_done", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("load_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
    check("load_not_busy", {31'd0, busy}, 32'd0);

    run(2'd2, 8'h00, 4'd3, 8'h2D, "rol3");
    run(2'd0, 8'hA5, 4'd0, 8'hA5, "reload1");
    run(2'd3, 8'h00, 4'd1, 8'hD2, "ror1");
    run(2'd0, 8'hA5, 4'd0, 8'hA5, "reload2");
    run(2'd2, 8'h00, 4'd8, 8'hA5, "rol8");

    run(2'd0, 8'h00, 4'd0, 8'h00, "clear1");
    issue(2'd1, 8'h0B, 4'd4, 8'h0D, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("shl_step", {24'd0, usr_q}, {24'd0, shl_seq[i]});
    end
    wait_idle();

    run(2'd0, 8'h00, 4'd0, 8'h00, "clear2");
    run(2'd1, 8'h0B, 4'd12, 8'h00, "shl12");
    run(2'd0, 8'h77, 4'd0, 8'h77, "load77");

    // Count-0 rotate with cmd_valid held high and the op changing while not ready.
    issue(2'd2, 8'h00, 4'd0, 8'h77, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 8'h3C;
    bus.cmd_count = 4'd0;
    check("cnt0_done_timing", {31'd0, done}, 32'd1);
    check("cnt0_reg", {24'd0, usr_q}, 32'h77);
    check("cnt0_not_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("cnt0_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
    exp_q.push_back(8'h3C);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("held_valid_load", {24'd0, usr_q}, 32'h3C);
    wait_idle();

    run(2'd0, 8'h81, 4'd0, 8'h81, "load81");
    issue(2'd2, 8'h00, 4'd5, 8'h00, 1'b0);
    @(negedge clk);
    check("abort_step1", {24'd0, usr_q}, 32'h03);
    @(negedge clk);
    check("abort_step2", {24'd0, usr_q}, 32'h06);
    reset = 1'b0;
    #1;
    check("abort_rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("abort_rst_busy",  {31'd0, busy}, 32'd0);
    check("abort_rst_ctrl",  {30'd0, usr_ctrl}, 32'd3);
    check("abort_rst_data",  {24'd0, usr_data}, 32'h06);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_hold", {24'd0, usr_q}, 32'h06);
      check("abort_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    end
    run(2'd0, 8'h5A, 4'd0, 8'h5A, "post_abort_load");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
